sr_bank_driver: RTL and testbench
=================================

// Module: sr_bank_driver
// PURPOSE
//  Write-side controller for a bank of W SR flip-flops (srff-style: {s,r}=10 set, 01 reset, 00 hold).
//  Accepts target-word commands over valid/ready and computes per-bit set/reset/hold excitation.
//  Drives s/r for one cycle, then verifies the bank's q feedback and retries on mismatch.
//  Guarantees the bank never sees the invalid {s,r}=11 condition on any bit.
// PARAMETERS
//  W          8   bank width (bits)
//  MAX_RETRY  2   re-drive attempts after the first failed check before err
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   controller can accept a command (high only in IDLE)
//  cmd_data   in   W   target value per bit
//  cmd_mask   in   W   1 = bit is written; 0 = bit is held
//  s          out  W   set excitation to bank (registered)
//  r          out  W   reset excitation to bank (registered)
//  q_fb       in   W   bank q outputs
//  busy       out  1   command in progress (DRIVE or CHECK)
//  done       out  1   one-cycle pulse: command verified
//  err        out  1   one-cycle pulse: retries exhausted
//  err_bits   out  W   masked mismatching bits from the final check; held until next accept
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, s=r=0, done=err=0, err_bits=0, retry count=0.
//   cmd_ready=1 once rst deasserts.
//  Invariant, every cycle, including reset: (s & r) == 0.
//  FSM states: IDLE, DRIVE, CHECK.
//  IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge E0:
//   - latch data/mask; retry count=0; err_bits=0; go to DRIVE.
//   - register s = mask & data & ~q_fb; r = mask & ~data & q_fb.
//   - Bits that already match, or are unmasked, get {s,r}=00.
//  DRIVE (exactly one cycle): s/r valid. Edge E1: bank latches; s=r=0; go to CHECK.
//  CHECK (one cycle): compute mm = mask & (q_fb ^ data). Edge E2:
//   - mm==0: go to IDLE; done=1 for one cycle.
//   - mm!=0 and retry count<MAX_RETRY: retry count++; re-register s/r from current q_fb; go to DRIVE.
//   - mm!=0 and retry count==MAX_RETRY: err_bits=mm; go to IDLE; err=1 for one cycle.
//  Timing: no-retry latency is accept edge -> done high after E2 (2 cycles). Each retry adds 2 cycles.
//  cmd_ready goes high in the same cycle as done/err. Back-to-back commands are allowed.
//  mask=0: full DRIVE/CHECK path runs with s=r=0; done at E2.
//  cmd_data/cmd_mask are ignored outside the accept edge; latched copies are used throughout.
//  q_fb changing during DRIVE is ignored (s/r are already registered).
//  Reset mid-command: s/r drop to 0 asynchronously; the command is abandoned with no done/err.
//  busy = (state != IDLE). done and err are never high together.
// STRUCTURE
//  sr_drv_pkg:
//   - state enum {IDLE, DRIVE, CHECK}
//   - excitation encodings EXC_HOLD=2'b00, EXC_SET=2'b10, EXC_RESET=2'b01 ({s,r} order)
//   - retry counter width function clog2(MAX_RETRY+1)
//  sr_excite: per-bit combinational cell (target, mask, q -> s, r), instantiated W times via generate.
//  Top level holds the FSM, data/mask latches, retry counter, output registers, and compare logic.
// TESTING
//  T1: q=8'h00, cmd data=8'hA5 mask=8'hFF -> DRIVE s=8'hA5 r=8'h00; done at E2; q=8'hA5; err=0.
//  T2: q=8'hF0, data=8'h0F mask=8'h3C -> s=8'h0C r=8'h30; final q=8'hCC; bits outside mask unchanged.
//  T3: bench model forces bit3 stuck at 0, data=8'h08 mask=8'h08, MAX_RETRY=2 ->
//      3 DRIVE phases each with s=8'h08; err pulse 6 cycles after accept; err_bits=8'h08; no done.
//  T4: back-to-back: cmd_valid held high with two commands ->
//      second accepted the cycle done pulses; each done 2 cycles after its accept.
//  T5: rst asserted during DRIVE with s=8'hFF -> s=r=0 immediately (before next clk);
//      after release: IDLE, cmd_ready=1, no done/err.
//  T6: random cmds, 1k cycles, bank = W srff models -> assert (s&r)==0 every cycle;
//      q matches data under mask after every done.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// sr_drv_pkg: shared state, excitation encodings and sizing helper for the SR bank driver
package sr_drv_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    localparam logic [1:0] EXC_HOLD  = 2'b00;
    localparam logic [1:0] EXC_SET   = 2'b10;
    localparam logic [1:0] EXC_RESET = 2'b01;

    // width of a counter that must hold 0..max_retry, never narrower than one bit
    function automatic int retry_w(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/sr_excite.sv
// sr_excite: per-bit SR excitation from target, write mask and present q
module sr_excite
    import sr_drv_pkg::*;
(
    input  logic target,
    input  logic mask,
    input  logic q,
    output logic s,
    output logic r
);

    // unmasked or already-correct bits hold, so {s,r}=11 cannot be produced
    always_comb {s, r} = (!mask || target == q) ? EXC_HOLD : (target ? EXC_SET : EXC_RESET);

endmodule

// File: rtl/sr_bank_driver.sv
// sr_bank_driver: drives an SR flip-flop bank to a masked target word, verifies and retries
module sr_bank_driver
    import sr_drv_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_data,
    input  logic [W-1:0] cmd_mask,
    output logic [W-1:0] s,
    output logic [W-1:0] r,
    input  logic [W-1:0] q_fb,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] err_bits
);

    localparam int RW = retry_w(MAX_RETRY);

    state_t         state, next;
    logic [W-1:0]   data_q, mask_q, tgt, msk, exc_s, exc_r, mm;
    logic [RW-1:0]  retry;
    logic           accept, mismatch, redrive, fail;

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign mm        = mask_q & (q_fb ^ data_q);
    assign mismatch  = (state == CHECK) && (mm != '0);
    assign redrive   = mismatch && (retry < RW'(MAX_RETRY));
    assign fail      = mismatch && !redrive;

    // at accept the excitation comes from the incoming command, on retry from the latched one
    assign tgt = (state == IDLE) ? cmd_data : data_q;
    assign msk = (state == IDLE) ? cmd_mask : mask_q;

    for (genvar i = 0; i < W; i++) begin : g_bit
        sr_excite u_exc (
            .target (tgt[i]),
            .mask   (msk[i]),
            .q      (q_fb[i]),
            .s      (exc_s[i]),
            .r      (exc_r[i])
        );
    end

    // next-state selection
    always_comb begin
        next = IDLE;
        next = (state == IDLE)  ? (accept ? DRIVE : IDLE) :
               (state == DRIVE) ? CHECK :
               (redrive ? DRIVE : IDLE);
    end

    // state, latched command, retry count and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            retry    <= '0;
            s        <= '0;
            r        <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_bits <= '0;
        end else begin
            state    <= next;
            data_q   <= accept ? cmd_data : data_q;
            mask_q   <= accept ? cmd_mask : mask_q;
            retry    <= accept ? '0 : (redrive ? retry + 1'b1 : retry);
            s        <= (accept || redrive) ? exc_s : '0;
            r        <= (accept || redrive) ? exc_r : '0;
            done     <= (state == CHECK) && (mm == '0);
            err      <= fail;
            err_bits <= accept ? '0 : (fail ? mm : err_bits);
        end
    end

endmodule

// File: tb/tb_sr_bank_driver.sv
// tb_sr_bank_driver: vector table, corner sequences and randomized check against an SR bank model
module tb_sr_bank_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, busy, done, err;
    logic [7:0] cmd_data = '0, cmd_mask = '0;
    logic [7:0] s, r, err_bits;
    logic [7:0] q_raw, q_fb;
    logic [7:0] stuck0 = '0, stuck1 = '0, load_val = '0;
    logic       load_en = 1'b1;
    int         checks = 0, errors = 0;

    typedef struct packed {
        logic [7:0] q0, data, mask, exp_s, exp_r, exp_q;
    } vec_t;
    vec_t vt [5];

    sr_bank_driver #(.W(8), .MAX_RETRY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_mask  (cmd_mask),
        .s         (s),
        .r         (r),
        .q_fb      (q_fb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_bits  (err_bits)
    );

    always #5 clk = ~clk;

    // bank of SR flip-flops, optional preload, and stuck-at faults on the feedback
    assign q_fb = (q_raw & ~stuck0) | stuck1;
    always @(posedge clk) q_raw <= load_en ? load_val : ((q_raw & ~r) | s);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // invariants on every cycle, reset included
    always @(negedge clk) begin
        chk("s_and_r", s & r, 0);
        chk("done_and_err", done & err, 0);
        chk("ready_and_busy", cmd_ready & busy, 0);
    end

    task automatic preload(input logic [7:0] v);
        @(negedge clk);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic run_vec(input int i);
        preload(vt[i].q0);
        chk($sformatf("v%0d_ready", i), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_data  = vt[i].data;
        cmd_mask  = vt[i].mask;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = ~vt[i].data;
        cmd_mask  = ~vt[i].mask;
        chk($sformatf("v%0d_s", i), s, vt[i].exp_s);
        chk($sformatf("v%0d_r", i), r, vt[i].exp_r);
        chk($sformatf("v%0d_busy", i), busy, 1);
        @(negedge clk);
        chk($sformatf("v%0d_s_check", i), s | r, 0);
        chk($sformatf("v%0d_done_early", i), done, 0);
        @(negedge clk);
        chk($sformatf("v%0d_done", i), done, 1);
        chk($sformatf("v%0d_err", i), err, 0);
        chk($sformatf("v%0d_q", i), q_fb, vt[i].exp_q);
    endtask

    initial begin
        logic [7:0] d, m, bad;
        int lat, drives, err_lat, k;
        logic done_seen;

        vt[0] = '{8'h00, 8'hA5, 8'hFF, 8'hA5, 8'h00, 8'hA5};
        vt[1] = '{8'hF0, 8'h0F, 8'h3C, 8'h0C, 8'h30, 8'hCC};
        vt[2] = '{8'h5A, 8'h33, 8'h00, 8'h00, 8'h00, 8'h5A};
        vt[3] = '{8'h96, 8'h96, 8'hFF, 8'h00, 8'h00, 8'h96};
        vt[4] = '{8'hFF, 8'h00, 8'h81, 8'h00, 8'h81, 8'h7E};

        @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_bits", err_bits, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_ready", cmd_ready, 1);

        for (int i = 0; i < 5; i++) run_vec(i);

        // bit 3 stuck at 0: initial drive plus two retries, then err
        preload(8'h00);
        stuck0    = 8'h08;
        cmd_valid = 1'b1;
        cmd_data  = 8'h08;
        cmd_mask  = 8'h08;
        @(negedge clk);
        cmd_valid = 1'b0;
        drives = 0;
        err_lat = -1;
        done_seen = 1'b0;
        for (int t = 0; t < 10 && err_lat < 0; t++) begin
            if (t > 0) @(negedge clk);
            if (s != 0) begin
                drives++;
                chk("stuck_s", s, 8'h08);
            end
            if (done) done_seen = 1'b1;
            if (err) err_lat = t;
        end
        chk("stuck_drives", drives, 3);
        chk("stuck_err_lat", err_lat, 6);
        chk("stuck_no_done", done_seen, 0);
        chk("stuck_err_bits", err_bits, 8'h08);
        @(negedge clk);
        chk("stuck_err_pulse", err, 0);
        chk("stuck_err_bits_held", err_bits, 8'h08);
        stuck0 = '0;

        // back-to-back commands with cmd_valid held high
        preload(8'h00);
        cmd_valid = 1'b1;
        cmd_data  = 8'h3C;
        cmd_mask  = 8'hFF;
        @(negedge clk);
        chk("b2b_s_a", s, 8'h3C);
        cmd_data = 8'hC3;
        cmd_mask = 8'h0F;
        @(negedge clk);
        chk("b2b_done_early", done, 0);
        @(negedge clk);
        chk("b2b_done_a", done, 1);
        chk("b2b_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_busy_b", busy, 1);
        chk("b2b_s_b", s, 8'h03);
        chk("b2b_r_b", r, 8'h0C);
        @(negedge clk);
        chk("b2b_done_mid", done, 0);
        @(negedge clk);
        chk("b2b_done_b", done, 1);
        chk("b2b_q_b", q_fb, 8'h33);

        // reset in the middle of DRIVE
        preload(8'h00);
        cmd_valid = 1'b1;
        cmd_data  = 8'hFF;
        cmd_mask  = 8'hFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_rst_s_before", s, 8'hFF);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_s", s, 0);
        chk("mid_rst_r", r, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("post_rst_ready", cmd_ready, 1);
            chk("post_rst_done", done, 0);
            chk("post_rst_err", err, 0);
        end

        // random commands, occasionally with one stuck bit; outcome predicted from masks
        for (int n = 0; n < 140; n++) begin
            @(negedge clk);
            stuck0 = '0;
            stuck1 = '0;
            if ($urandom_range(3) == 0) begin
                k = $urandom_range(7);
                if ($urandom_range(1) == 1) stuck0[k] = 1'b1;
                else stuck1[k] = 1'b1;
            end
            d = 8'($urandom);
            m = 8'($urandom);
            bad = m & ((stuck0 & d) | (stuck1 & ~d));
            chk("rnd_ready", cmd_ready, 1);
            cmd_valid = 1'b1;
            cmd_data  = d;
            cmd_mask  = m;
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_data  = 8'($urandom);
            cmd_mask  = 8'($urandom);
            lat = 0;
            while (!done && !err && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            if (bad == 0) begin
                chk("rnd_done", done, 1);
                chk("rnd_done_lat", lat, 2);
                chk("rnd_q", q_fb & m, d & m);
            end else begin
                chk("rnd_err", err, 1);
                chk("rnd_err_lat", lat, 6);
                chk("rnd_err_bits", err_bits, bad);
            end
            repeat ($urandom_range(2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
